// File: rtl/dual_serial_tx_if.sv
// Two-wire serial transmit bundle: load request, cancel and words in, serial A/B lines and framing out.
interface dual_serial_tx_if #(
  parameter int WIDTH = 9
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             ser_a;
  logic             ser_b;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, data_a, data_b,
    input  ser_a, ser_b, valid, busy, done
  );

  modport slave (
    input  start, abort, data_a, data_b,
    output ser_a, ser_b, valid, busy, done
  );
endinterface

// File: rtl/dual_serial_tx.sv
// Two-channel lockstep parallel-to-serial transmitter, one bit per clk on A and B.
// First bit one cycle after an accepted start; start is ignored while busy (no queueing).
module dual_serial_tx #(
  parameter int WIDTH     = 9,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  dual_serial_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_a_q, ser_a_d, ser_b_q, ser_b_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    ser_a_d = ser_a_q;
    ser_b_d = ser_b_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // abort beats start when both arrive in IDLE
        if (bus.start && !bus.abort) begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          if (MSB_FIRST) begin
            ser_a_d = bus.data_a[WIDTH-1];
            ser_b_d = bus.data_b[WIDTH-1];
            sh_a_d  = bus.data_a << 1;
            sh_b_d  = bus.data_b << 1;
          end else begin
            ser_a_d = bus.data_a[0];
            ser_b_d = bus.data_b[0];
            sh_a_d  = bus.data_a >> 1;
            sh_b_d  = bus.data_b >> 1;
          end
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
          ser_a_d = 1'b0;
          ser_b_d = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q < CW'(WIDTH)) begin
          cnt_d = cnt_q + CW'(1);
          if (MSB_FIRST) begin
            ser_a_d = sh_a_q[WIDTH-1];
            ser_b_d = sh_b_q[WIDTH-1];
            sh_a_d  = sh_a_q << 1;
            sh_b_d  = sh_b_q << 1;
          end else begin
            ser_a_d = sh_a_q[0];
            ser_b_d = sh_b_q[0];
            sh_a_d  = sh_a_q >> 1;
            sh_b_d  = sh_b_q >> 1;
          end
        end else begin
          state_d = DONE;
          ser_a_d = 1'b0;
          ser_b_d = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        // abort here lands in the same place as the normal exit
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ser_a_d = 1'b0;
        ser_b_d = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      ser_a_q <= 1'b0;
      ser_b_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      ser_a_q <= ser_a_d;
      ser_b_q <= ser_b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ser_a = ser_a_q;
  assign bus.ser_b = ser_b_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_dual_serial_tx.sv
// Bench for dual_serial_tx: LSB-first and MSB-first instances share stimulus and are
// compared every cycle against a queue of expected output frames.
module tb_dual_serial_tx;
  localparam int W = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start, abort;
  logic [W-1:0] da, db;

  dual_serial_tx_if #(.WIDTH(W)) if_l ();
  dual_serial_tx_if #(.WIDTH(W)) if_m ();

  assign if_l.start  = start;
  assign if_l.abort  = abort;
  assign if_l.data_a = da;
  assign if_l.data_b = db;
  assign if_m.start  = start;
  assign if_m.abort  = abort;
  assign if_m.data_a = da;
  assign if_m.data_b = db;

  dual_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(if_l.slave));
  dual_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(if_m.slave));

  int checks = 0;
  int errors = 0;

  // Each frame: {lsb {valid,busy,done,ser_a,ser_b}, msb {valid,busy,done,ser_a,ser_b}}
  logic [9:0]   q[$];
  logic [4:0]   exp_l, exp_m;
  logic         m_busy;
  logic [W-1:0] cap_la, cap_lb, cap_ma, cap_mb;

  task automatic push_transfer(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < W; i++)
      q.push_back({3'b110, a[i], b[i], 3'b110, a[W-1-i], b[W-1-i]});
    q.push_back({5'b01100, 5'b01100});
  endtask

  task automatic check_outputs(input string tag);
    logic [4:0] obs_l, obs_m;
    obs_l = {if_l.valid, if_l.busy, if_l.done, if_l.ser_a, if_l.ser_b};
    obs_m = {if_m.valid, if_m.busy, if_m.done, if_m.ser_a, if_m.ser_b};
    checks++;
    assert (obs_l === exp_l) else begin
      errors++;
      $error("FAIL %s lsb {v,busy,done,a,b} observed=%b expected=%b t=%0t", tag, obs_l, exp_l, $time);
    end
    checks++;
    assert (obs_m === exp_m) else begin
      errors++;
      $error("FAIL %s msb {v,busy,done,a,b} observed=%b expected=%b t=%0t", tag, obs_m, exp_m, $time);
    end
    if (obs_l[4]) begin
      cap_la = {obs_l[1], cap_la[W-1:1]};
      cap_lb = {obs_l[0], cap_lb[W-1:1]};
    end
    if (obs_m[4]) begin
      cap_ma = {obs_m[1], cap_ma[W-1:1]};
      cap_mb = {obs_m[0], cap_mb[W-1:1]};
    end
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive inputs just after an edge, advance one edge, update the model, sample 1ns later.
  task automatic step(input logic s, input logic ab, input string tag);
    logic [9:0] e;
    start = s;
    abort = ab;
    @(posedge clk);
    if (!reset) q.delete();
    else if (ab && m_busy) q.delete();
    else if (!m_busy && s && !ab) push_transfer(da, db);
    e = 10'd0;
    if (reset && q.size() > 0) e = q.pop_front();
    exp_l  = e[9:5];
    exp_m  = e[4:0];
    m_busy = e[8];
    #1;
    check_outputs(tag);
  endtask

  task automatic clear_caps();
    cap_la = '0; cap_lb = '0; cap_ma = '0; cap_mb = '0;
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b1;
    abort  = 1'b0;
    da     = 9'b011101110;
    db     = 9'b001000100;
    m_busy = 1'b0;
    clear_caps();

    // reset held with start high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset_hold");
    reset = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "idle_after_reset");

    // spec pattern, both bit orders
    step(1'b1, 1'b0, "pattern_accept");
    for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, "pattern_run");
    check_word("pattern_lsb_a", cap_la, 9'b011101110);
    check_word("pattern_lsb_b", cap_lb, 9'b001000100);
    check_word("pattern_msb_a", cap_ma, 9'b011101110);
    check_word("pattern_msb_b", cap_mb, 9'b001000100);

    // asymmetric word: the single 1 lands first for LSB, last for MSB
    clear_caps();
    da = 9'b000000001;
    db = 9'b100000000;
    step(1'b1, 1'b0, "asym_accept");
    da = 9'b111111111;
    db = 9'b010101010;
    for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, "asym_run");
    check_word("asym_lsb_a", cap_la, 9'b000000001);
    check_word("asym_msb_a", cap_ma, 9'b100000000);
    check_word("asym_msb_b", cap_mb, 9'b000000001);

    // start held high: back-to-back with a 2-cycle gap, and mid-transfer start pulses
    for (int i = 0; i < 3 * (W + 2) + 1; i++) begin
      da = W'($urandom);
      db = W'($urandom);
      step(1'b1, 1'b0, "start_held");
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "drain");

    // abort during the 4th valid cycle
    da = W'($urandom);
    db = W'($urandom);
    step(1'b1, 1'b0, "abort_accept");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "abort_pre");
    step(1'b0, 1'b1, "abort_hit");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "abort_after");
    clear_caps();
    da = 9'b110010111;
    db = 9'b001101000;
    step(1'b1, 1'b1, "abort_start_idle");
    step(1'b1, 1'b0, "restart_accept");
    for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, "restart_run");
    check_word("restart_lsb_a", cap_la, 9'b110010111);
    check_word("restart_lsb_b", cap_lb, 9'b001101000);

    // async reset during the 5th valid cycle
    step(1'b1, 1'b0, "rst_accept");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "rst_pre");
    reset = 1'b0;
    #1;
    q.delete();
    exp_l  = 5'd0;
    exp_m  = 5'd0;
    m_busy = 1'b0;
    check_outputs("rst_async");
    step(1'b0, 1'b0, "rst_low");
    reset = 1'b1;
    step(1'b0, 1'b0, "rst_released");
    clear_caps();
    da = 9'b101100110;
    db = 9'b010011001;
    step(1'b1, 1'b0, "post_rst_accept");
    for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, "post_rst_run");
    check_word("post_rst_lsb_a", cap_la, 9'b101100110);
    check_word("post_rst_lsb_b", cap_lb, 9'b010011001);

    // randomized traffic with aborts and data churn
    for (int i = 0; i < 1500; i++) begin
      da = W'($urandom);
      db = W'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
